ahbl_rom_ctrl: RTL and testbench
================================

# ahbl_rom_ctrl

AHB-Lite slave front end for the boot/program ROM macro. Sits between the AHB-Lite bus matrix and the ROM (32-bit word, synchronous read, one-cycle registered latency, `EN`/`A`/`Do` port). Converts read transfers into ROM word accesses with zero wait states and answers illegal transfers with a two-cycle ERROR response. Suppresses redundant ROM reads of the same word to save power.

## Interface
Parameters:
- `MEM_WORDS`, 8192: ROM depth in 32-bit words.
- `ADR_WIDTH`, 13: ROM word-address width; `2**ADR_WIDTH >= MEM_WORDS`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `HCLK` in 1: bus clock, also clocks the ROM.
- `HRESETn` in 1: asynchronous active-low reset.
- `HSEL` in 1: slave select from the address decoder.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: transfer type; bit 1 set means NONSEQ/SEQ.
- `HWRITE` in 1: write when 1.
- `HSIZE` in 3: transfer size.
- `HREADY` in 1: bus-wide ready; the previous transfer completes.
- `HREADYOUT` out 1: this slave's ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `HRDATA` out 32: read data.
- `ROM_EN` out 1: ROM read enable.
- `ROM_A` out `ADR_WIDTH`: ROM word address.
- `ROM_Do` in 32: ROM registered read data.

## Operation
- Accept condition in the address phase: `HSEL & HREADY & HTRANS[1]`.
- A transfer is illegal when any of these holds:
  - `HWRITE=1`
  - `HSIZE>2`
  - `HSIZE=1` and `HADDR[0]=1`
  - `HSIZE=2` and `HADDR[1:0]!=0`
  - the word address `HADDR[ADR_WIDTH+1:2] >= MEM_WORDS`
- FSM states:
  - `IDLE`: no data phase pending.
  - `RD`: read data phase.
  - `ERR1`: first ERROR cycle.
  - `ERR2`: second ERROR cycle.
- Transitions, taken from `IDLE`, `RD` or `ERR2` on each accepted transfer:
  - accepted legal read goes to `RD`
  - accepted illegal transfer goes to `ERR1`
  - no accept goes to `IDLE`
  - `ERR1` goes to `ERR2` unconditionally
- ROM drive, combinational from the address phase:
  - `ROM_A = HADDR[ADR_WIDTH+1:2]`.
  - `ROM_EN = 1` only for an accepted legal read that misses.
- Hit/miss tracking:
  - Registers: `last_valid` and `last_addr`.
  - A hit is `last_valid & (ROM_A == last_addr)`.
  - On a miss fetch, update `last_addr` and set `last_valid`.
  - On a hit, `ROM_EN = 0`. The ROM holds `Do`, so the data is still correct.
- Data phase outputs:
  - `RD`: `HREADYOUT=1`, `HRESP=0`, `HRDATA=ROM_Do`.
  - `ERR1`: `HREADYOUT=0`, `HRESP=1`.
  - `ERR2`: `HREADYOUT=1`, `HRESP=1`.
  - `HRDATA=0` in every state other than `RD`.
- Narrow reads return the full aligned word. The master selects byte lanes (little-endian).
- `ROM_EN` is forced to 0 while `HRESETn=0`.

## Timing
- Reset values:
  - state `IDLE`, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `ROM_EN=0`
  - `last_valid=0`, `last_addr=0`
- Read latency:
  - Address phase in cycle N; `ROM_EN`/`ROM_A` are sampled by the ROM at the rising edge ending N.
  - `HRDATA` is valid in data-phase cycle N+1 with zero wait states.
- Back-to-back reads are supported every cycle: a SEQ burst of k words completes in k+1 cycles.
- Error timing: an illegal transfer in cycle N gives `ERR1` in N+1 (`HREADYOUT=0`) and `ERR2` in N+2 (`HREADYOUT=1`).
- No transfer is accepted during `ERR1`, because `HREADY=0`.
- A transfer presented during `ERR2` is accepted normally.
- When `HREADY=0` because another slave is stalling, nothing is accepted, `ROM_EN=0`, and the state holds.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous), and the pending data phase is abandoned.
- After reset release, the first read is always a miss.
- Idle cycles (`HTRANS=IDLE/BUSY`) give an OKAY zero-wait response and leave `last_valid` unchanged.

## Structure
- Shared package `ahbl_pkg` holds:
  - the `HTRANS` encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - the `HRESP` encodings
  - the `HSIZE` constants
  - the FSM state typedef
- No sub-module. The FSM, error check and hit tracker are small and live in one module.
- The ROM macro is instantiated by the parent, not inside this block.

## Test plan
- Single read at `HADDR=0x0000_0010`, ROM word 4 = `0xDEADBEEF` -> `ROM_EN=1`, `ROM_A=4` in the address cycle; next cycle `HRDATA=0xDEADBEEF`, `HREADYOUT=1`, `HRESP=0`.
- 4-beat INCR SEQ burst from `0x0` over words `0x11,0x22,0x33,0x44` -> `ROM_A=0,1,2,3` on consecutive cycles; data phases return `0x11..0x44` with no wait states.
- Two back-to-back reads of `0x20` -> `ROM_EN=1` only on the first; both data phases return word 8.
- Write to `0x100` -> `ERR1` (`HREADYOUT=0`, `HRESP=1`) then `ERR2` (`HREADYOUT=1`, `HRESP=1`); `ROM_EN` stays 0.
- Read with `HSIZE=2`, `HADDR=0x2` -> two-cycle ERROR response. Read with `HSIZE=0`, `HADDR=0x3` -> OKAY response carrying the full word 0.
- `HRESETn` pulsed low during the data phase of a read -> `HRDATA=0` and `HREADYOUT=1` immediately. A subsequent read of the same address asserts `ROM_EN=1` (miss).

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and ROM front-end FSM state type.
// Imported by the ROM controller and any other AHB-Lite slaves.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_ERR1 = 2'd2;
    localparam state_t ST_ERR2 = 2'd3;

endpackage

// File: rtl/ahbl_rom_ctrl.sv
// AHB-Lite read-only slave for the boot ROM macro.
// Zero-wait reads, two-cycle ERROR, repeated-word read suppression.
module ahbl_rom_ctrl
    import ahbl_pkg::*;
#(
    parameter int MEM_WORDS = 8192,
    parameter int ADR_WIDTH = 13
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic                 ROM_EN,
    output logic [ADR_WIDTH-1:0] ROM_A,
    input  logic [31:0]          ROM_Do
);

    localparam logic [ADR_WIDTH:0] DEPTH = (ADR_WIDTH + 1)'(MEM_WORDS);

    state_t                 state;
    state_t                 state_nx;
    logic                   accept;
    logic                   illegal;
    logic                   rd_ok;
    logic                   hit;
    logic                   last_valid;
    logic [ADR_WIDTH-1:0]   last_addr;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, HTRANS[0], HADDR[31:ADR_WIDTH+2]};

    assign ROM_A  = HADDR[ADR_WIDTH+1:2];
    assign accept = HSEL & HREADY & HTRANS[1];

    assign illegal = HWRITE
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                   | ({1'b0, ROM_A} >= DEPTH);

    assign rd_ok  = accept & ~illegal;
    assign hit    = last_valid & (ROM_A == last_addr);
    assign ROM_EN = HRESETn & rd_ok & ~hit;

    // Next data-phase state; a stalled bus holds everything but ERR1.
    always_comb begin
        state_nx = state;
        if (state == ST_ERR1) begin
            state_nx = ST_ERR2;
        end else if (HREADY) begin
            if (rd_ok) begin
                state_nx = ST_RD;
            end else if (accept) begin
                state_nx = ST_ERR1;
            end else begin
                state_nx = ST_IDLE;
            end
        end
    end

    // Data-phase state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Remember the word the ROM output is currently holding.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (ROM_EN) begin
            last_valid <= 1'b1;
            last_addr  <= ROM_A;
        end
    end

    assign HREADYOUT = (state != ST_ERR1);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2))
                     ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state == ST_RD) ? ROM_Do : 32'h0;

endmodule

// File: tb/tb_ahbl_rom_ctrl.sv
// Self-checking bench for ahbl_rom_ctrl with a behavioural ROM.
// Directed scenarios followed by randomized transfers.
module tb_ahbl_rom_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        stall;
    wire         HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        ROM_EN;
    logic [12:0] ROM_A;
    logic [31:0] ROM_Do;

    logic [31:0] mem [8192];

    int checks = 0;
    int errors = 0;

    // expected data phase: 0 idle, 1 read, 2 err first, 3 err second
    int          ph;
    logic [31:0] exp_data;
    bit          held_v;
    int          held_w;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT & ~stall;

    always @(posedge HCLK) begin
        if (ROM_EN) ROM_Do <= mem[ROM_A];
    end

    ahbl_rom_ctrl dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .ROM_EN   (ROM_EN),
        .ROM_A    (ROM_A),
        .ROM_Do   (ROM_Do)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit sel, input logic [31:0] addr,
                        input logic [1:0] tr, input bit wr,
                        input logic [2:0] sz, input bit st);
        bit hr, acc, ill, en;
        int w;
        @(negedge HCLK);
        check("HREADYOUT", 32'(HREADYOUT), (ph == 2) ? 0 : 1);
        check("HRESP", 32'(HRESP), (ph >= 2) ? 1 : 0);
        check("HRDATA", HRDATA, (ph == 1) ? exp_data : 32'h0);
        HSEL = sel; HADDR = addr; HTRANS = tr;
        HWRITE = wr; HSIZE = sz; stall = st;
        #1;
        hr  = (ph != 2) && !st;
        acc = sel && hr && tr[1];
        w   = int'(addr[14:2]);
        ill = wr || (sz > 2) || (sz == 1 && addr[0]) ||
              (sz == 2 && addr[1:0] != 2'b00) || (w >= 8192);
        en  = acc && !ill && !(held_v && held_w == w);
        check("ROM_EN", 32'(ROM_EN), 32'(en));
        check("ROM_A", 32'(ROM_A), 32'(w));
        if (ph == 2) begin
            ph = 3;
        end else if (hr) begin
            if (!acc) ph = 0;
            else if (ill) ph = 2;
            else begin
                ph = 1;
                exp_data = mem[w];
            end
        end
        if (en) begin
            held_v = 1;
            held_w = w;
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [1:0] tr,
                      input logic [2:0] sz);
        step(1, addr, tr, 0, sz, 0);
    endtask

    task automatic idle();
        step(0, 32'h0, 2'b00, 0, 3'd2, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        mem[0] = 32'h11; mem[1] = 32'h22;
        mem[2] = 32'h33; mem[3] = 32'h44;
        ROM_Do = 32'h0;
        ph = 0; exp_data = 0; held_v = 0; held_w = 0;
        HRESETn = 1'b0; HSEL = 0; HADDR = 0; HTRANS = 0;
        HWRITE = 0; HSIZE = 3'd2; stall = 0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst HREADYOUT", 32'(HREADYOUT), 1);
        check("rst HRESP", 32'(HRESP), 0);
        check("rst HRDATA", HRDATA, 0);
        check("rst ROM_EN", 32'(ROM_EN), 0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        rd(32'h10, 2'b10, 3'd2);
        idle();

        rd(32'h0, 2'b10, 3'd2);
        rd(32'h4, 2'b11, 3'd2);
        rd(32'h8, 2'b11, 3'd2);
        rd(32'hC, 2'b11, 3'd2);
        idle();

        rd(32'h20, 2'b10, 3'd2);
        rd(32'h20, 2'b10, 3'd2);
        idle();

        step(1, 32'h100, 2'b10, 1, 3'd2, 0);
        rd(32'h20, 2'b10, 3'd2);
        idle();
        idle();

        rd(32'h2, 2'b10, 3'd2);
        idle();
        rd(32'h24, 2'b10, 3'd2);
        rd(32'h3, 2'b10, 3'd0);
        idle();

        step(1, 32'h10, 2'b10, 0, 3'd2, 1);
        step(1, 32'h10, 2'b10, 0, 3'd2, 1);
        idle();

        rd(32'h40, 2'b10, 3'd2);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("mid-rst HRDATA", HRDATA, 0);
        check("mid-rst HREADYOUT", 32'(HREADYOUT), 1);
        check("mid-rst HRESP", 32'(HRESP), 0);
        check("mid-rst ROM_EN", 32'(ROM_EN), 0);
        ph = 0; held_v = 0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        rd(32'h40, 2'b10, 3'd2);
        rd(32'h40, 2'b10, 3'd2);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            bit          st;
            a = ($urandom & 32'hFFFF_0000) |
                (32'($urandom_range(0, 15)) << 2) |
                (($urandom_range(0, 3) == 0) ? ($urandom & 32'h3) : 32'h0);
            st = (ph == 0) && ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 5) != 0, a, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 1) == 0) ? 3'd2
                                             : 3'($urandom_range(0, 3)),
                 st);
        end
        idle();
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
